// File: rtl/decode_stage.sv
// Decode + operand fetch: owns a 32-entry regfile and a RAW scoreboard, emits ALU operands via one registered slot.
// Latency 1 cycle; in_ready_o drops on downstream backpressure or an unresolved source hazard.
module decode_stage #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          in_instr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATAWIDTH-1:0] a_o,
    output logic [DATAWIDTH-1:0] b_o,
    output logic [3:0]           opcode_o,
    output logic [4:0]           rd_o,
    output logic [DATAWIDTH-1:0] store_data_o,
    output logic                 illegal_o,
    input  logic                 wb_en_i,
    input  logic [4:0]           wb_addr_i,
    input  logic [DATAWIDTH-1:0] wb_data_i
);

    logic [DATAWIDTH-1:0] regs [32];
    logic [31:0]          pending;

    logic [3:0]           op;
    logic [4:0]           rd, rs1, rs2;
    logic [12:0]          imm;
    logic                 is_lw, is_sw, is_ill, is_r;
    logic                 wb_hit1, wb_hit2, hazard, accept, set_pend;
    logic [DATAWIDTH-1:0] rs1_val, rs2_val, imm_ext;

    assign {op, rd, rs1, rs2, imm} = in_instr_i;
    assign imm_ext = {{(DATAWIDTH-13){imm[12]}}, imm};

    always_comb begin
        is_lw  = (op == 4'd1);
        is_sw  = (op == 4'd2);
        is_ill = (op >= 4'd9);
        is_r   = !is_lw && !is_sw && !is_ill;
    end

    assign wb_hit1 = wb_en_i && (wb_addr_i == rs1);
    assign wb_hit2 = wb_en_i && (wb_addr_i == rs2);

    // Write-through bypass so a dependent instruction can issue in the writeback cycle.
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (wb_hit1) rs1_val = wb_data_i;
        if (wb_hit2) rs2_val = wb_data_i;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    always_comb begin
        hazard = 1'b0;
        if (!is_ill && pending[rs1] && !wb_hit1)
            hazard = 1'b1;
        if ((is_r || is_sw) && pending[rs2] && !wb_hit2)
            hazard = 1'b1;
    end

    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard;
    assign accept     = in_valid_i && in_ready_o;
    assign set_pend   = accept && (is_r || is_lw) && (rd != 5'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Set is applied after clear so it wins on a same-register collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending <= '0;
        end else begin
            if (wb_en_i)
                pending[wb_addr_i] <= 1'b0;
            if (set_pend)
                pending[rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o  <= 1'b0;
            illegal_o    <= 1'b0;
            a_o          <= '0;
            b_o          <= '0;
            store_data_o <= '0;
            opcode_o     <= '0;
            rd_o         <= '0;
        end else begin
            illegal_o <= accept && is_ill;
            if (accept && !is_ill) begin
                out_valid_o  <= 1'b1;
                opcode_o     <= op;
                a_o          <= rs1_val;
                b_o          <= is_r ? rs2_val : imm_ext;
                store_data_o <= is_sw ? rs2_val : '0;
                rd_o         <= is_sw ? 5'd0 : rd;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scenario bench for decode_stage: expected slots queued at issue, popped when the slot appears.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, illegal, wb_en;
    logic [31:0] instr, a, b, store_data, wb_data;
    logic [3:0]  opcode;
    logic [4:0]  rd, wb_addr;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  op;
        logic [4:0]  rd;
    } slot_t;

    slot_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    decode_stage #(.DATAWIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(instr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .a_o(a), .b_o(b), .opcode_o(opcode), .rd_o(rd),
        .store_data_o(store_data), .illegal_o(illegal),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [12:0] imm);
        return {op, d, s1, s2, imm};
    endfunction

    function automatic slot_t mks(input logic [31:0] ea, input logic [31:0] eb,
                                  input logic [31:0] esd, input logic [3:0] eop,
                                  input logic [4:0] erd);
        return {ea, eb, esd, eop, erd};
    endfunction

    function slot_t slot_now();
        return {a, b, store_data, opcode, rd};
    endfunction

    function automatic slot_t pop_exp();
        if (exp_q.size() == 0) return '1;
        return exp_q.pop_front();
    endfunction

    // Starts and ends on a falling edge.
    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        wb_en = 1'b1; wb_addr = addr; wb_data = data;
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input slot_t e, output int waited);
        waited = 0;
        in_valid = 1'b1;
        instr = ins;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (in_ready) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || slot_now() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b ill=%b slot=%h want 0 0 0", out_valid, illegal, slot_now());
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add();
        int w;
        slot_t e;
        wb_write(5'd1, 32'd5);
        wb_write(5'd2, 32'd7);
        issue(mk(4'd0, 5'd3, 5'd1, 5'd2, 13'd0), mks(32'd5, 32'd7, 32'd0, 4'd0, 5'd3), w);
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL add_slot: got v=%b %h want v=1 %h", out_valid, slot_now(), e);
        end
    endtask

    task automatic test_hazard();
        int w;
        slot_t e;
        issue(mk(4'd1, 5'd4, 5'd1, 5'd0, 13'h1FFC), mks(32'd5, 32'hFFFF_FFFC, 32'd0, 4'd1, 5'd4), w);
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL lw_slot: got v=%b %h want v=1 %h", out_valid, slot_now(), e);
        end
        in_valid = 1'b1;
        instr = mk(4'd3, 5'd5, 5'd4, 5'd1, 13'd0);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_stall_first: got in_ready=%b want 0", in_ready);
        end
        // Middle stall cycle writes back an unrelated register; it must not release the stall.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wb_en = (k == 1); wb_addr = 5'd10; wb_data = 32'h55;
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_stall_%0d: got in_ready=%b want 0", k, in_ready);
            end
        end
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wb_release: got in_ready=%b want 1", in_ready);
        end
        if (in_ready) exp_q.push_back(mks(32'd9, 32'd5, 32'd0, 4'd3, 5'd5));
        @(negedge clk);
        in_valid = 1'b0; wb_en = 1'b0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL bypass_slot: got v=%b %h want v=1 %h", out_valid, slot_now(), e);
        end
    endtask

    task automatic test_backpressure();
        int w;
        slot_t e;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL slot_drain: got v=%b want 0", out_valid);
        end
        out_ready = 1'b0;
        issue(mk(4'd6, 5'd8, 5'd1, 5'd2, 13'd0), mks(32'd5, 32'd7, 32'd0, 4'd6, 5'd8), w);
        e = pop_exp();
        in_valid = 1'b1;
        instr = mk(4'd7, 5'd9, 5'd1, 5'd2, 13'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || slot_now() !== e) begin
                n_fail++;
                $display("FAIL hold_%0d: got rdy=%b v=%b %h want rdy=0 v=1 %h",
                         k, in_ready, out_valid, slot_now(), e);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got in_ready=%b want 1", in_ready);
        end
        if (in_ready) exp_q.push_back(mks(32'd5, 32'd7, 32'd0, 4'd7, 5'd9));
        @(negedge clk);
        in_valid = 1'b0;
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL or_slot: got v=%b %h want v=1 %h", out_valid, slot_now(), e);
        end
    endtask

    task automatic test_store();
        int w;
        slot_t e;
        wb_write(5'd1, 32'h100);
        wb_write(5'd2, 32'hAB);
        issue(mk(4'd2, 5'd11, 5'd1, 5'd2, 13'd4), mks(32'h100, 32'd4, 32'hAB, 4'd2, 5'd0), w);
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL sw_slot: got v=%b %h want v=1 %h", out_valid, slot_now(), e);
        end
        // Reads r11, the rd field of the store: no scoreboard bit may have been set.
        issue(mk(4'd0, 5'd12, 5'd11, 5'd11, 13'd0), mks(32'd0, 32'd0, 32'd0, 4'd0, 5'd12), w);
        e = pop_exp();
        n_checks++;
        if (w !== 0 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL sw_no_pending: got wait=%0d %h want wait=0 %h", w, slot_now(), e);
        end
    endtask

    task automatic test_back_to_back();
        slot_t e;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            instr = mk(4'd0, 5'(20 + i), 5'd1, 5'd2, 13'd0);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready);
            end
            if (in_ready) exp_q.push_back(mks(32'h100, 32'hAB, 32'd0, 4'd0, 5'(20 + i)));
            @(negedge clk);
            e = pop_exp();
            n_checks++;
            if (out_valid !== 1'b1 || slot_now() !== e) begin
                n_fail++;
                $display("FAIL b2b_slot_%0d: got v=%b %h want v=1 %h", i, out_valid, slot_now(), e);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_illegal();
        int w;
        slot_t e;
        in_valid = 1'b1;
        instr = mk(4'hC, 5'd14, 5'd12, 5'd12, 13'd0);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (illegal !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse: got ill=%b v=%b want ill=1 v=0", illegal, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_width: got ill=%b want 0", illegal);
        end
        issue(mk(4'd0, 5'd0, 5'd1, 5'd2, 13'd0), mks(32'h100, 32'hAB, 32'd0, 4'd0, 5'd0), w);
        e = pop_exp();
        n_checks++;
        if (out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL add_r0_slot: got v=%b %h want v=1 %h", out_valid, slot_now(), e);
        end
        issue(mk(4'd8, 5'd6, 5'd0, 5'd0, 13'd0), mks(32'd0, 32'd0, 32'd0, 4'd8, 5'd6), w);
        e = pop_exp();
        n_checks++;
        if (w !== 0 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL xor_r0: got wait=%0d %h want wait=0 %h", w, slot_now(), e);
        end
    endtask

    task automatic test_reset_midflight();
        int w;
        slot_t e;
        out_ready = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b want 0", out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        issue(mk(4'd0, 5'd7, 5'd3, 5'd3, 13'd0), mks(32'd0, 32'd0, 32'd0, 4'd0, 5'd7), w);
        e = pop_exp();
        n_checks++;
        if (w !== 0 || out_valid !== 1'b1 || slot_now() !== e) begin
            n_fail++;
            $display("FAIL post_reset_issue: got wait=%0d v=%b %h want wait=0 v=1 %h",
                     w, out_valid, slot_now(), e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_hazard();
        test_backpressure();
        test_store();
        test_back_to_back();
        test_illegal();
        test_reset_midflight();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-fetch stage that sits directly upstream of the execute ALU. It accepts 32-bit instructions over a valid/ready handshake and reads the 32-entry register file it owns. It produces the ALU operand pair, the 4-bit ALU opcode, the destination register and the store data through a single registered output slot. A per-register scoreboard stalls issue on read-after-write hazards until the matching writeback arrives.

## Interface
- DATAWIDTH, 32, width of registers, operands and writeback data
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  instruction present on in_instr_i
- in_ready_o  out  1  stage accepts the instruction this cycle
- in_instr_i  in  32  instruction: [31:28] opcode, [27:23] rd, [22:18] rs1, [17:13] rs2, [12:0] imm13
- out_valid_o  out  1  output slot holds a decoded instruction
- out_ready_i  in  1  downstream consumes the slot this cycle
- a_o  out  DATAWIDTH  ALU operand a (rs1 value)
- b_o  out  DATAWIDTH  ALU operand b (rs2 value, or sign-extended imm13 for lw/sw)
- opcode_o  out  4  ALU opcode, passed through
- rd_o  out  5  destination register (0 for sw)
- store_data_o  out  DATAWIDTH  rs2 value for sw, 0 otherwise
- illegal_o  out  1  one-cycle pulse when an opcode 9..15 instruction is accepted
- wb_en_i  in  1  register-file write enable
- wb_addr_i  in  5  write address
- wb_data_i  in  DATAWIDTH  write data

## Operation
- Opcodes:
  - 0 add, 3 sub, 4 mul, 5 div, 6 and, 7 or, 8 xor: R-type. a=R[rs1], b=R[rs2]. Writes rd.
  - 1 lw: a=R[rs1], b=sext(imm13). Writes rd.
  - 2 sw: a=R[rs1], b=sext(imm13), store_data=R[rs2]. rd_o=0. Writes nothing.
- Register file: 32 x DATAWIDTH. R0 reads as 0. Writes to address 0 are discarded.
- Write-through bypass: when wb_en_i=1 and wb_addr_i equals a source register (other than 0), the read returns wb_data_i in the same cycle.
- Scoreboard: pending[31:0], with pending[0] permanently 0.
  - Set pending[rd] when an instruction that writes rd (rd≠0) is accepted.
  - Clear pending[wb_addr_i] on wb_en_i.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- Hazard: a used source register s has pending[s]=1 and is not being written back this cycle (wb_en_i && wb_addr_i==s).
  - R-type uses rs1 and rs2. lw uses rs1. sw uses rs1 and rs2.
  - Illegal opcodes use no sources.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard. It is combinational from in_instr_i, the scoreboard and the wb_* inputs.
- Accept: in_valid_i && in_ready_o.
  - Legal opcode: load the output slot and set out_valid_o=1.
  - Illegal opcode: the instruction is consumed, nothing is loaded, and illegal_o pulses.
- Output slot:
  - Without an accept, out_ready_i && out_valid_o clears out_valid_o.
  - Slot fields hold their value while out_valid_o=1 && !out_ready_i.
- sext(imm13): bit 12 is replicated up to DATAWIDTH.

## Timing
- Reset, asynchronous and effective immediately:
  - out_valid_o=0, illegal_o=0.
  - a_o, b_o, store_data_o, opcode_o, rd_o all 0.
  - All registers 0, pending all 0.
- Latency: an instruction accepted on edge N is visible on the outputs after edge N (1 cycle).
- Throughput: 1 instruction/cycle when there are no hazards and out_ready_i=1.
- Back-to-back dependent instructions stall until the writeback cycle. In that cycle the dependent instruction is accepted with the bypassed value, so the minimum bubble is zero.
- Writeback and issue occupy independent ports. A write to a register not read this cycle has no effect on in_ready_o.
- Reset asserted mid-stall or with out_valid_o=1: the slot and all pending bits are lost. Upstream must replay.

## Test plan
- Reset, then wb R1=5 and R2=7. Issue add r3,r1,r2 with out_ready_i=1 -> next cycle out_valid_o=1, a_o=5, b_o=7, opcode_o=0, rd_o=3.
- Issue lw r4,r1,imm13=0x1FFC -> b_o=0xFFFFFFFC, rd_o=4. Then issue sub r5,r4,r1 -> in_ready_o=0 until wb R4=9. In the wb cycle in_ready_o=1, and next cycle a_o=9.
- Hold out_ready_i=0 with out_valid_o=1 and present a new instruction -> in_ready_o=0, and the outputs stay stable for 3 cycles.
- sw r1,r2,imm=4 with R1=0x100, R2=0xAB -> a_o=0x100, b_o=4, store_data_o=0xAB, rd_o=0. No pending bit is set.
- Instruction with opcode 0xC -> accepted, illegal_o=1 for one cycle, out_valid_o stays 0. add r0,r1,r2 followed by xor r6,r0,r0 -> no stall, a_o=b_o=0.
- Assert rst_i asynchronously while pending[3]=1 and out_valid_o=1 -> out_valid_o drops immediately, and after release add r7,r3,r3 issues without a stall with a_o=0.
